conv_weight_buffer: RTL and testbench
=====================================

# conv_weight_buffer

Parametrised convolution weight buffer between the weight BRAM reader and the CNN MAC array. It accepts a scalar weight stream and stores whole filters in slot memory. It presents one KxK kernel window per input channel per handshake. It supports a streaming mode, where slots are recycled, and a resident mode, where all filters are loaded once and replayed until an explicit reload.

## Interface
- DATA_WIDTH, 16, signed weight word width
- KERNEL_SIZE, 3, square kernel dimension K (≥1)
- IN_CHANNELS, 4, input channels per filter C (≥1)
- OUT_CHANNELS, 8, filters per layer F (≥1)
- SLOTS, 2, filter slots buffered S (≥1)
- RESIDENT, 0, 1 = resident/replay mode; legal only when S ≥ F
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  buffer accepts a write this cycle
- wr_data  in  DATA_WIDTH  signed weight
- rd_valid  out  1  window_out holds a complete filter channel
- rd_ready  in  1  consumer accepts window
- window_out  out  DATA_WIDTH x K x K  signed KxK window, row-major
- rd_channel_idx  out  clog2(C) (min 1)  channel of current window
- rd_filter_idx  out  clog2(F) (min 1)  layer filter index of current window
- rd_last  out  1  current window is channel C-1 of filter F-1
- fill_count  out  clog2(S+1)  complete filters stored
- reload  in  1  resident mode: discard contents, accept a fresh layer load
- err  out  1  sticky protocol error (see Configuration)

## Operation
- Write order: filter, then kernel position p = 0..K²-1 (row = p/K, col = p%K), then channel (innermost). One word per wr_valid && wr_ready.
- A write completes a filter when channel = C-1 and p = K²-1. The write slot pointer then advances modulo S, or modulo F in resident mode.
- Read order: one window per channel 0..C-1 of the head filter. A read completes a filter on a handshake with rd_channel_idx = C-1.
- window_out is driven combinationally from the head slot and current channel. It is not zero-gated. It is stable while rd_valid && !rd_ready.
- rd_valid = fill_count > 0.
- rd_filter_idx counts layer filters 0..F-1 and wraps to 0 after F-1, independently of slot index.
- Streaming mode (RESIDENT=0):
  - wr_ready = fill_count < S.
  - Write-complete increments fill_count; read-complete decrements it; both in the same cycle leave it unchanged.
  - Write and read slot pointers wrap modulo S.
- Resident mode (RESIDENT=1):
  - States LOAD and REPLAY.
  - LOAD: wr_ready = 1. Writes fill slots 0..F-1 and fill_count increments per filter. rd_valid = fill_count > 0, so reads may begin before the load finishes.
  - On the F-th write-complete, transition to REPLAY. In REPLAY, wr_ready = 0.
  - fill_count never decrements in resident mode. The read slot wraps modulo F, replaying indefinitely.
  - reload (any state) → LOAD with fill_count = 0 and all pointers = 0, next cycle. A write or read handshake in the same cycle as reload is ignored.
- Arithmetic: slot column offset = slot*K + col, sized clog2(S*K). All pointers are unsigned and wrap explicitly at compare, never by overflow.

## Timing
- Write to visible latency: the cycle after the completing write, rd_valid = 1 and window_out reflects the new filter.
- Read throughput: one window per cycle with rd_ready held high.
- Full boundary: when fill_count = S, wr_ready = 0. A read-complete in that cycle raises wr_ready the next cycle (no combinational lookahead).
- Empty boundary: when fill_count = 0, rd_valid = 0 and rd_ready is ignored.
- Reset (any time, including mid-filter): all pointers, fill_count and err = 0; state = LOAD. Outputs become wr_ready = 1, rd_valid = 0, rd_channel_idx = 0, rd_filter_idx = 0, rd_last = 0. Storage contents are not cleared, so window_out is undefined until the first filter completes.
- reload has lower priority than rst_n and higher priority than all other activity.

## Configuration
- WBUF_ERR_EN defined:
  - err sets on wr_valid && !wr_ready (the word is dropped).
  - err sets on rd_ready && !rd_valid (underflow request).
  - err sets on RESIDENT=1 with S < F (checked at reset release).
  - err clears only on rst_n.
- WBUF_ERR_EN undefined: err is tied to 0 and no checking logic is built.

## Test plan
- K=3, C=4, S=2, F=8, streaming, rd_ready=0: write 72 words → fill_count=2, wr_ready=0; word 73 with WBUF_ERR_EN → err=1 and data dropped.
- Same config, write weight value = flat index: read 4 windows → channel 2 window[1][2] = 4*5+2 = 22; after 4th handshake fill_count=1 and wr_ready=1 next cycle.
- Simultaneous completing write and completing read with fill_count=1 → fill_count stays 1, slot pointers both advance.
- Resident, S=F=4: load 144 words → REPLAY, wr_ready=0; 32 read handshakes → rd_filter_idx sequence 0..3 twice, rd_last on handshakes 16 and 32, fill_count stays 4.
- Resident: pulse reload mid-replay → next cycle rd_valid=0, wr_ready=1, fill_count=0; new load replays new data.
- Assert rst_n low mid-filter (after 20 writes) → next cycle all pointers 0, rd_valid=0; a fresh 36-word filter reads back correctly.

Source files
------------

// File: rtl/conv_weight_buffer_if.sv
// conv_weight_buffer_if: weight write stream, kernel window read port and status of the conv weight buffer
interface conv_weight_buffer_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int KERNEL_SIZE  = 3,
    parameter int IN_CHANNELS  = 4,
    parameter int OUT_CHANNELS = 8,
    parameter int SLOTS        = 2
);
    localparam int CW = IN_CHANNELS > 1 ? $clog2(IN_CHANNELS) : 1;
    localparam int FW = OUT_CHANNELS > 1 ? $clog2(OUT_CHANNELS) : 1;
    localparam int NW = $clog2(SLOTS + 1);
    logic                                          wr_valid;
    logic                                          wr_ready;
    logic signed [DATA_WIDTH-1:0]                  wr_data;
    logic                                          rd_valid;
    logic                                          rd_ready;
    logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window_out;
    logic [CW-1:0]                                 rd_channel_idx;
    logic [FW-1:0]                                 rd_filter_idx;
    logic                                          rd_last;
    logic [NW-1:0]                                 fill_count;
    logic                                          reload;
    logic                                          err;
    modport master (
        output wr_valid, wr_data, rd_ready, reload,
        input  wr_ready, rd_valid, window_out, rd_channel_idx, rd_filter_idx, rd_last, fill_count, err
    );
    modport slave (
        input  wr_valid, wr_data, rd_ready, reload,
        output wr_ready, rd_valid, window_out, rd_channel_idx, rd_filter_idx, rd_last, fill_count, err
    );
endinterface

// File: rtl/conv_weight_buffer.sv
// conv_weight_buffer: slot-buffered conv filters presented as one KxK window per input channel.
// Define WBUF_ERR_EN to build the sticky protocol error checker; otherwise err is tied low.
module conv_weight_buffer #(
    parameter int DATA_WIDTH   = 16,
    parameter int KERNEL_SIZE  = 3,
    parameter int IN_CHANNELS  = 4,
    parameter int OUT_CHANNELS = 8,
    parameter int SLOTS        = 2,
    parameter bit RESIDENT     = 1'b0
) (
    input logic clk,
    input logic rst_n,
    conv_weight_buffer_if.slave bus
);
    localparam int K  = KERNEL_SIZE;
    localparam int C  = IN_CHANNELS;
    localparam int F  = OUT_CHANNELS;
    localparam int S  = SLOTS;
    localparam int NS = RESIDENT ? F : S;
    localparam int KW = K > 1 ? $clog2(K) : 1;
    localparam int CW = C > 1 ? $clog2(C) : 1;
    localparam int FW = F > 1 ? $clog2(F) : 1;
    localparam int SW = NS > 1 ? $clog2(NS) : 1;
    localparam int OW = S * K > 1 ? $clog2(S * K) : 1;
    localparam int NW = $clog2(S + 1);
    typedef enum logic {LOAD, REPLAY} state_t;
    state_t state;
    logic signed [DATA_WIDTH-1:0] mem [K][S*K][C];
    logic [KW-1:0] wr_row, wr_col;
    logic [CW-1:0] wr_ch, rd_ch;
    logic [SW-1:0] wr_slot, rd_slot;
    logic [FW-1:0] rd_filt;
    logic [NW-1:0] fill;
    logic [OW-1:0] wr_off;
    logic rl, wr_fire, wr_done, rd_fire, rd_done;
    always_comb begin
        rl = RESIDENT && bus.reload;
        bus.wr_ready = RESIDENT ? state == LOAD : fill < NW'(S);
        bus.rd_valid = fill != '0;
        wr_fire = bus.wr_valid && bus.wr_ready && !rl;
        wr_done = wr_fire && wr_ch == CW'(C - 1) && wr_col == KW'(K - 1) && wr_row == KW'(K - 1);
        rd_fire = bus.rd_valid && bus.rd_ready && !rl;
        rd_done = rd_fire && rd_ch == CW'(C - 1);
        bus.rd_last = bus.rd_valid && rd_ch == CW'(C - 1) && rd_filt == FW'(F - 1);
        bus.rd_channel_idx = rd_ch;
        bus.rd_filter_idx = rd_filt;
        bus.fill_count = fill;
        wr_off = OW'(wr_slot) * OW'(K) + OW'(wr_col);
    end
    always_ff @(posedge clk) begin
        if (!rst_n || rl) begin
            state <= LOAD;
            wr_row <= '0;
            wr_col <= '0;
            wr_ch <= '0;
            wr_slot <= '0;
            rd_ch <= '0;
            rd_slot <= '0;
            rd_filt <= '0;
            fill <= '0;
        end else begin
            if (wr_fire) begin
                wr_ch <= wr_ch == CW'(C - 1) ? '0 : wr_ch + 1'b1;
                if (wr_ch == CW'(C - 1)) begin
                    wr_col <= wr_col == KW'(K - 1) ? '0 : wr_col + 1'b1;
                    if (wr_col == KW'(K - 1)) wr_row <= wr_row == KW'(K - 1) ? '0 : wr_row + 1'b1;
                end
            end
            if (wr_done) wr_slot <= wr_slot == SW'(NS - 1) ? '0 : wr_slot + 1'b1;
            if (rd_fire) rd_ch <= rd_ch == CW'(C - 1) ? '0 : rd_ch + 1'b1;
            if (rd_done) begin
                rd_slot <= rd_slot == SW'(NS - 1) ? '0 : rd_slot + 1'b1;
                rd_filt <= rd_filt == FW'(F - 1) ? '0 : rd_filt + 1'b1;
            end
            // resident contents are replayed, so reads never release a filter
            if (RESIDENT) begin
                if (wr_done) fill <= fill + 1'b1;
                if (wr_done && fill == NW'(F - 1)) state <= REPLAY;
            end else begin
                fill <= fill + NW'(wr_done) - NW'(rd_done);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_row][wr_off][wr_ch] <= bus.wr_data;
    end
    for (genvar r = 0; r < K; r++) begin : g_r
        for (genvar c = 0; c < K; c++) begin : g_c
            assign bus.window_out[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = mem[r][OW'(rd_slot)*OW'(K)+OW'(c)][rd_ch];
        end
    end
`ifdef WBUF_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) bus.err <= 1'b0;
        else bus.err <= bus.err || (bus.wr_valid && !bus.wr_ready) || (bus.rd_ready && !bus.rd_valid) || (RESIDENT && S < F);
    end
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_conv_weight_buffer.sv
// tb_conv_weight_buffer: directed stimulus on a streaming and a resident buffer,
// checked every cycle against queue/array models plus literal spot checks.
module tb_conv_weight_buffer;
    localparam int DW = 16, K = 3, C = 4, FA = 8, SA = 2, FB = 4, SB = 4, FL = K * K * C;
`ifdef WBUF_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    conv_weight_buffer_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IN_CHANNELS(C), .OUT_CHANNELS(FA), .SLOTS(SA)) ia ();
    conv_weight_buffer_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IN_CHANNELS(C), .OUT_CHANNELS(FB), .SLOTS(SB)) ib ();
    conv_weight_buffer #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IN_CHANNELS(C), .OUT_CHANNELS(FA), .SLOTS(SA), .RESIDENT(1'b0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    conv_weight_buffer #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IN_CHANNELS(C), .OUT_CHANNELS(FB), .SLOTS(SB), .RESIDENT(1'b1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input int d);
        ia.wr_valid = 1'b1;
        ia.wr_data = DW'(d);
        tick();
        ia.wr_valid = 1'b0;
    endtask

    task automatic wr_b(input int d);
        ib.wr_valid = 1'b1;
        ib.wr_data = DW'(d);
        tick();
        ib.wr_valid = 1'b0;
    endtask

    // streaming model: complete filters queued word by word; resident model: flat layer image
    logic [DW-1:0] fqa[$], cura[$];
    logic [DW-1:0] memb [FB*FL];
    int rcha = 0, rfia = 0, fa = 0;
    int rchb = 0, rfib = 0, fb = 0, wpb = 0;
    bit erra = 1'b0, errb = 1'b0, armed = 1'b0;
    logic [DW*K*K-1:0] ewa, ewb;

    always @(negedge clk) begin
        fa = fqa.size() / FL;
        if (armed) begin
            chk("a_wr_ready", ia.wr_ready, fa < SA);
            chk("a_rd_valid", ia.rd_valid, fa > 0);
            chk("a_fill", ia.fill_count, fa);
            chk("a_channel", ia.rd_channel_idx, rcha);
            chk("a_filter", ia.rd_filter_idx, rfia);
            chk("a_last", ia.rd_last, fa > 0 && rcha == C - 1 && rfia == FA - 1);
            chk("a_err", ia.err, erra);
            if (fa > 0) begin
                for (int p = 0; p < K * K; p++) ewa[p*DW +: DW] = fqa[p*C + rcha];
                chk("a_window", ia.window_out, ewa);
            end
            chk("b_wr_ready", ib.wr_ready, fb < FB);
            chk("b_rd_valid", ib.rd_valid, fb > 0);
            chk("b_fill", ib.fill_count, fb);
            chk("b_channel", ib.rd_channel_idx, rchb);
            chk("b_filter", ib.rd_filter_idx, rfib);
            chk("b_last", ib.rd_last, fb > 0 && rchb == C - 1 && rfib == FB - 1);
            chk("b_err", ib.err, errb);
            if (fb > 0) begin
                for (int p = 0; p < K * K; p++) ewb[p*DW +: DW] = memb[rfib*FL + p*C + rchb];
                chk("b_window", ib.window_out, ewb);
            end
        end
        if (!rst_n) begin
            fqa.delete();
            cura.delete();
            rcha = 0; rfia = 0; erra = 1'b0;
            fb = 0; wpb = 0; rchb = 0; rfib = 0; errb = 1'b0;
            armed = 1'b1;
        end else begin
            erra = erra | (ERR_EN && ((ia.wr_valid && fa >= SA) || (ia.rd_ready && fa == 0)));
            if (ia.rd_ready && fa > 0) begin
                if (rcha == C - 1) begin
                    repeat (FL) void'(fqa.pop_front());
                    rcha = 0;
                    rfia = (rfia + 1) % FA;
                end else rcha++;
            end
            if (ia.wr_valid && fa < SA) begin
                cura.push_back(ia.wr_data);
                if (cura.size() == FL) begin
                    foreach (cura[i]) fqa.push_back(cura[i]);
                    cura.delete();
                end
            end
            errb = errb | (ERR_EN && ((ib.wr_valid && fb >= FB) || (ib.rd_ready && fb == 0)));
            if (ib.reload) begin
                fb = 0; wpb = 0; rchb = 0; rfib = 0;
            end else begin
                if (ib.rd_ready && fb > 0) begin
                    if (rchb == C - 1) begin
                        rchb = 0;
                        rfib = (rfib + 1) % FB;
                    end else rchb++;
                end
                if (ib.wr_valid && fb < FB) begin
                    memb[wpb] = ib.wr_data;
                    wpb++;
                    if (wpb % FL == 0) fb++;
                end
            end
        end
    end

    logic [DW-1:0] wds [6*FL];
    initial begin
        int n;
        bit acc;
        ia.wr_valid = 1'b0; ia.wr_data = '0; ia.rd_ready = 1'b0; ia.reload = 1'b0;
        ib.wr_valid = 1'b0; ib.wr_data = '0; ib.rd_ready = 1'b0; ib.reload = 1'b0;
        foreach (wds[i]) wds[i] = DW'($urandom);
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_a_wr_ready", ia.wr_ready, 1);
        chk("rst_a_rd_valid", ia.rd_valid, 0);
        chk("rst_a_last", ia.rd_last, 0);
        chk("rst_b_wr_ready", ib.wr_ready, 1);
        // fill both streaming slots, then one word too many
        for (int i = 0; i < 2 * FL; i++) wr_a(i);
        chk("full_fill", ia.fill_count, 2);
        chk("full_wr_ready", ia.wr_ready, 0);
        wr_a(999);
        chk("drop_err", ia.err, ERR_EN);
        chk("drop_fill", ia.fill_count, 2);
        ia.rd_ready = 1'b1;
        repeat (2) tick();
        chk("ch2_idx", ia.rd_channel_idx, 2);
        chk("ch2_win_1_2", ia.window_out[5*DW +: DW], 22);
        repeat (2) tick();
        ia.rd_ready = 1'b0;
        chk("after_read_fill", ia.fill_count, 1);
        chk("after_read_wr_ready", ia.wr_ready, 1);
        chk("after_read_filter", ia.rd_filter_idx, 1);
        // completing write and completing read land on the same edge
        for (int i = 0; i < FL - 1; i++) wr_a(100 + i);
        ia.rd_ready = 1'b1;
        repeat (3) tick();
        ia.wr_valid = 1'b1;
        ia.wr_data = DW'(100 + FL - 1);
        tick();
        ia.wr_valid = 1'b0;
        ia.rd_ready = 1'b0;
        chk("simul_fill", ia.fill_count, 1);
        chk("simul_filter", ia.rd_filter_idx, 2);
        chk("simul_win0", ia.window_out[DW-1:0], 100);
        // six more filters with concurrent, throttled reads
        n = 0;
        for (int cyc = 0; cyc < 3000 && !(n == 6 * FL && ia.fill_count == 0); cyc++) begin
            ia.wr_valid = n < 6 * FL;
            ia.wr_data = n < 6 * FL ? wds[n] : '0;
            ia.rd_ready = $urandom_range(0, 3) != 0;
            acc = ia.wr_valid && ia.wr_ready;
            tick();
            if (acc) n++;
        end
        ia.wr_valid = 1'b0;
        ia.rd_ready = 1'b0;
        chk("stream_drain", n == 6 * FL && ia.fill_count == 0, 1);
        chk("stream_filter_wrap", ia.rd_filter_idx, 1);
        // reset in the middle of a filter
        for (int i = 0; i < 20; i++) wr_a(600 + i);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_rd_valid", ia.rd_valid, 0);
        chk("midrst_fill", ia.fill_count, 0);
        chk("midrst_channel", ia.rd_channel_idx, 0);
        chk("midrst_err", ia.err, 0);
        for (int i = 0; i < FL; i++) wr_a(500 + i);
        chk("fresh_rd_valid", ia.rd_valid, 1);
        chk("fresh_win0", ia.window_out[DW-1:0], 500);
        ia.rd_ready = 1'b1;
        tick();
        chk("fresh_ch1_win1", ia.window_out[DW +: DW], 505);
        repeat (3) tick();
        ia.rd_ready = 1'b0;
        chk("fresh_fill", ia.fill_count, 0);
        // resident layer load and replay
        for (int i = 0; i < FB * FL; i++) wr_b(1000 + i);
        chk("res_wr_ready", ib.wr_ready, 0);
        chk("res_fill", ib.fill_count, 4);
        chk("res_win0", ib.window_out[DW-1:0], 1000);
        ib.rd_ready = 1'b1;
        for (int h = 0; h < 32; h++) begin
            chk("res_seq_filter", ib.rd_filter_idx, (h / 4) % 4);
            chk("res_seq_last", ib.rd_last, h == 15 || h == 31);
            tick();
        end
        chk("res_fill_kept", ib.fill_count, 4);
        repeat (2) tick();
        ib.rd_ready = 1'b0;
        ib.reload = 1'b1;
        tick();
        ib.reload = 1'b0;
        chk("reload_rd_valid", ib.rd_valid, 0);
        chk("reload_wr_ready", ib.wr_ready, 1);
        chk("reload_fill", ib.fill_count, 0);
        chk("reload_channel", ib.rd_channel_idx, 0);
        for (int i = 0; i < FB * FL; i++) wr_b(3000 + i);
        chk("reload_win0", ib.window_out[DW-1:0], 3000);
        ib.rd_ready = 1'b1;
        repeat (8) tick();
        ib.rd_ready = 1'b0;
        chk("reload_filter", ib.rd_filter_idx, 2);
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
